// File: rtl/x1_ioctl_upload.sv
// Serves hps_io upload reads from a core-side byte RAM with a fixed read latency,
// and raises ioctl_upload_req when the core asks for a save.
module x1_ioctl_upload #(
    parameter int          AW           = 16,
    parameter int          SIZE         = 65536,
    parameter int          RD_LAT       = 2,
    parameter logic [7:0]  UPLOAD_INDEX = 8'h01,
    parameter int          REQ_TIMEOUT  = 1048575
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          save_req,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          ioctl_upload_req,
    output logic [7:0]    ioctl_upload_index,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_q,
    output logic          busy,
    output logic          done,
    output logic          err_oob
);

    localparam int CW = $clog2(REQ_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ARMED, S_FETCH, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [RD_LAT:0] vld_pipe, vld_pipe_nxt;
    logic [7:0]      din_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic            wait_nxt, mem_rd_nxt, err_nxt;
    logic            sel, in_bounds;

    assign sel                = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_bounds          = {7'd0, ioctl_addr} < 32'(SIZE);
    assign ioctl_upload_index = UPLOAD_INDEX;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        vld_pipe_nxt = {vld_pipe[RD_LAT-1:0], 1'b0};
        din_nxt      = ioctl_din;
        wait_nxt     = ioctl_wait;
        mem_rd_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        err_nxt      = err_oob;
        case (state)
            S_IDLE: begin
                if (sel) begin
                    state_nxt = S_ARMED;
                    err_nxt   = 1'b0;
                end else if (save_req) begin
                    state_nxt = S_REQ;
                    cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                if (sel) begin
                    state_nxt = S_ARMED;
                    err_nxt   = 1'b0;
                end else if (cnt == CW'(REQ_TIMEOUT - 1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_ARMED: begin
                if (!sel) begin
                    state_nxt = S_DONE;
                end else if (ioctl_rd) begin
                    if (in_bounds) begin
                        state_nxt       = S_FETCH;
                        mem_rd_nxt      = 1'b1;
                        mem_addr_nxt    = ioctl_addr[AW-1:0];
                        wait_nxt        = 1'b1;
                        vld_pipe_nxt[0] = 1'b1;
                    end else begin
                        din_nxt = 8'hFF;
                        err_nxt = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // Session abort wins over a byte landing the same cycle.
                if (!sel) begin
                    state_nxt    = S_DONE;
                    wait_nxt     = 1'b0;
                    vld_pipe_nxt = '0;
                end else if (vld_pipe[RD_LAT]) begin
                    state_nxt = S_ARMED;
                    din_nxt   = mem_q;
                    wait_nxt  = 1'b0;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            vld_pipe         <= '0;
            ioctl_din        <= 8'h00;
            ioctl_wait       <= 1'b0;
            ioctl_upload_req <= 1'b0;
            mem_rd           <= 1'b0;
            mem_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_oob          <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            vld_pipe         <= vld_pipe_nxt;
            ioctl_din        <= din_nxt;
            ioctl_wait       <= wait_nxt;
            ioctl_upload_req <= (state_nxt == S_REQ);
            mem_rd           <= mem_rd_nxt;
            mem_addr         <= mem_addr_nxt;
            busy             <= (state_nxt != S_IDLE);
            done             <= (state_nxt == S_DONE);
            err_oob          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_x1_ioctl_upload.sv
// Directed bench for x1_ioctl_upload: stimulus pushes expected bytes, a monitor
// pops and compares them whenever a fetch completes.
module tb_x1_ioctl_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        save_req, ioctl_upload, ioctl_rd;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din, ioctl_upload_index, mem_q;
    logic        ioctl_wait, ioctl_upload_req, mem_rd, busy, done, err_oob;
    logic [15:0] mem_addr;

    int tests = 0, fails = 0, rd_pulses = 0, p0, n;
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp, d1;
    logic       wait_q = 1'b0;

    x1_ioctl_upload #(
        .AW(16), .SIZE(65536), .RD_LAT(2), .UPLOAD_INDEX(8'h01), .REQ_TIMEOUT(100)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .save_req(save_req),
        .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ioctl_upload_req(ioctl_upload_req), .ioctl_upload_index(ioctl_upload_index),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
        .busy(busy), .done(done), .err_oob(err_oob)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] ram_val(input logic [15:0] a);
        if (a == 16'h0123) return 8'hA5;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    // RAM with exactly two cycles of latency; junk outside the valid slot.
    always @(posedge clk_sys) begin
        d1    <= mem_rd ? ram_val(mem_addr) : 8'hEE;
        mem_q <= d1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (mem_rd) rd_pulses <= rd_pulses + 1;
        if (reset_n && wait_q && !ioctl_wait && ioctl_upload) begin
            if (exp_q.size() == 0) chk("sb_unexpected_fetch", 1, 0);
            else begin
                sb_exp = exp_q.pop_front();
                chk("sb_din", 32'(ioctl_din), 32'(sb_exp));
            end
        end
        wait_q <= ioctl_wait;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_fetch();
        int k = 0;
        while (ioctl_wait && k < 20) begin
            tick();
            k++;
        end
        if (ioctl_wait) chk("wait_timeout", 32'(ioctl_wait), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; save_req = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0;
        ioctl_index = 8'h01; ioctl_addr = '0;
        repeat (3) tick();
        chk("rst_din", 32'(ioctl_din), 0);
        chk("rst_wait", 32'(ioctl_wait), 0);
        chk("rst_req", 32'(ioctl_upload_req), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_oob), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("upload_index", 32'(ioctl_upload_index), 32'h01);
        reset_n = 1'b1;
        tick();

        // 1: save request held until sel arrives 10 cycles later
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        n = 0;
        repeat (9) begin
            n += int'(ioctl_upload_req);
            tick();
        end
        ioctl_upload = 1'b1;
        n += int'(ioctl_upload_req);
        tick();
        chk("req_cycles", n, 10);
        chk("req_low_armed", 32'(ioctl_upload_req), 0);
        chk("busy_armed", 32'(busy), 1);

        // 2: single fetch latency
        p0 = rd_pulses;
        ioctl_addr = 25'h0123; ioctl_rd = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        ioctl_rd = 1'b0;
        chk("t2_mem_rd", 32'(mem_rd), 1);
        chk("t2_mem_addr", 32'(mem_addr), 32'h0123);
        chk("t2_wait1", 32'(ioctl_wait), 1);
        tick();
        chk("t2_mem_rd_pulse", 32'(mem_rd), 0);
        chk("t2_wait2", 32'(ioctl_wait), 1);
        tick();
        chk("t2_wait3", 32'(ioctl_wait), 1);
        tick();
        chk("t2_wait4", 32'(ioctl_wait), 0);
        chk("t2_din", 32'(ioctl_din), 32'hA5);
        chk("t2_pulses", rd_pulses - p0, 1);

        // 3: burst 0..255
        p0 = rd_pulses;
        for (int a = 0; a < 256; a++) begin
            ioctl_addr = 25'(a); ioctl_rd = 1'b1;
            exp_q.push_back(ram_val(16'(a)));
            tick();
            ioctl_rd = 1'b0;
            wait_fetch();
        end
        tick();
        chk("t3_pulses", rd_pulses - p0, 256);

        // 4: out of bounds read
        p0 = rd_pulses;
        ioctl_addr = 25'h10000; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("t4_din", 32'(ioctl_din), 32'hFF);
        chk("t4_wait", 32'(ioctl_wait), 0);
        chk("t4_err", 32'(err_oob), 1);
        repeat (4) tick();
        chk("t4_no_mem_rd", rd_pulses - p0, 0);
        ioctl_upload = 1'b0;
        tick();
        chk("t4_done", 32'(done), 1);
        tick();
        chk("t4_done_pulse", 32'(done), 0);
        chk("t4_idle", 32'(busy), 0);
        chk("t4_err_sticky", 32'(err_oob), 1);
        chk("t4_din_hold", 32'(ioctl_din), 32'hFF);
        ioctl_upload = 1'b1;
        tick();
        chk("t4_err_clear", 32'(err_oob), 0);

        // 5: session abort during fetch
        ioctl_addr = 25'h0123; ioctl_rd = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        ioctl_rd = 1'b0;
        wait_fetch();
        ioctl_addr = 25'h0200; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        ioctl_upload = 1'b0;
        chk("t5_wait_hi", 32'(ioctl_wait), 1);
        tick();
        chk("t5_wait_drop", 32'(ioctl_wait), 0);
        chk("t5_done", 32'(done), 1);
        chk("t5_din", 32'(ioctl_din), 32'hA5);
        tick();
        chk("t5_idle", 32'(busy), 0);
        repeat (3) tick();
        chk("t5_din_hold", 32'(ioctl_din), 32'hA5);

        // 6a: reset mid-fetch
        ioctl_upload = 1'b1;
        tick();
        ioctl_addr = 25'h0300; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        chk("t6_wait_hi", 32'(ioctl_wait), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_wait", 32'(ioctl_wait), 0);
        chk("t6_rst_mem_rd", 32'(mem_rd), 0);
        chk("t6_rst_din", 32'(ioctl_din), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_addr", 32'(mem_addr), 0);
        ioctl_upload = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        p0 = rd_pulses;
        repeat (6) tick();
        chk("t6_no_mem_rd", rd_pulses - p0, 0);
        chk("t6_din_after", 32'(ioctl_din), 0);

        // 6b: request timeout
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        n = 0;
        while (ioctl_upload_req && n < 200) begin
            n++;
            tick();
        end
        chk("t6_timeout_cycles", n, 100);
        chk("t6_timeout_idle", 32'(busy), 0);
        chk("t6_timeout_done", 32'(done), 0);

        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
